// File: rtl/guitar_judge.sv
// Note-judging and scoring engine: synchronises strum, judges hits/misses against
// the hit zone, keeps score/combo/multiplier and queues events for the processor.
module guitar_judge #(
  parameter int LANES      = 4,
  parameter int SCORE_W    = 32,
  parameter int COMBO_W    = 8,
  parameter int HIT_PTS    = 2,
  parameter int MISS_PTS   = 1,
  parameter int COMBO_STEP = 4,
  parameter int MULT_MAX   = 4,
  parameter int LOCKOUT    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               strum,
  input  logic [LANES-1:0]   buttons,
  input  logic [LANES-1:0]   intersections,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [2:0]         mult,
  output logic               hit,
  output logic               miss,
  output logic               evt_valid,
  output logic               evt_hit,
  input  logic               evt_ready,
  output logic               evt_drop,
  output logic               o_dbg_state
);

  localparam int CNT_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam int EXT_W = SCORE_W + 8;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  logic               r_s1, r_s2, r_sp;
  logic [1:0]         r_fill;
  logic               r_armed;
  logic               r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_score;
  logic [COMBO_W-1:0] r_combo;
  logic               r_hit, r_miss;
  logic               r_q0, r_q1;
  logic [1:0]         r_qcnt;
  logic               r_drop;

  logic               w_edge, w_is_hit, w_pop;
  logic [COMBO_W-1:0] w_step;
  logic [2:0]         w_mult;
  logic [EXT_W-1:0]   w_sum;
  logic [SCORE_W-1:0] w_score_hit, w_score_miss;

  assign w_edge   = r_s2 & ~r_sp & r_armed & (r_state == ST_IDLE);
  assign w_is_hit = (buttons == intersections) && (intersections != '0);
  assign w_pop    = (r_qcnt != 2'd0) & evt_ready;

  always_comb begin
    w_step = r_combo / COMBO_W'(COMBO_STEP);
    if (w_step >= COMBO_W'(MULT_MAX - 1)) w_mult = 3'(MULT_MAX);
    else                                  w_mult = 3'(w_step) + 3'd1;
  end

  assign w_sum        = {8'd0, r_score} + EXT_W'(HIT_PTS) * EXT_W'(w_mult);
  assign w_score_hit  = (w_sum[EXT_W-1:SCORE_W] != '0) ? '1 : w_sum[SCORE_W-1:0];
  assign w_score_miss = (r_score >= SCORE_W'(MISS_PTS)) ? r_score - SCORE_W'(MISS_PTS) : '0;

  // r_fill waits until s2 holds a real sample, so a strum held through reset never arms.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_s1 <= 1'b0; r_s2 <= 1'b0; r_sp <= 1'b0;
      r_fill <= 2'd0; r_armed <= 1'b0;
    end else begin
      r_s1 <= strum; r_s2 <= r_s1; r_sp <= r_s2;
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
      if (r_fill == 2'd2 && !r_s2) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE; r_cnt <= '0;
      r_score <= '0; r_combo <= '0;
      r_hit <= 1'b0; r_miss <= 1'b0;
    end else begin
      r_hit  <= w_edge & w_is_hit;
      r_miss <= w_edge & ~w_is_hit;
      if (r_state == ST_IDLE) begin
        if (w_edge) begin
          r_state <= ST_LOCK;
          r_cnt   <= CNT_W'(LOCKOUT - 1);
          if (w_is_hit) begin
            r_score <= w_score_hit;
            if (r_combo != '1) r_combo <= r_combo + 1'b1;
          end else begin
            r_score <= w_score_miss;
            r_combo <= '0;
          end
        end
      end else begin
        if (r_cnt == '0) r_state <= ST_IDLE;
        else             r_cnt   <= r_cnt - 1'b1;
      end
    end
  end

  // Two-entry event queue; a simultaneous pop frees the slot before the push lands.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q0 <= 1'b0; r_q1 <= 1'b0; r_qcnt <= 2'd0; r_drop <= 1'b0;
    end else if (w_pop && w_edge) begin
      if (r_qcnt == 2'd2) begin
        r_q0 <= r_q1; r_q1 <= w_is_hit;
      end else begin
        r_q0 <= w_is_hit;
      end
    end else if (w_pop) begin
      r_q0   <= r_q1;
      r_qcnt <= r_qcnt - 2'd1;
    end else if (w_edge) begin
      case (r_qcnt)
        2'd0:    begin r_q0 <= w_is_hit; r_qcnt <= 2'd1; end
        2'd1:    begin r_q1 <= w_is_hit; r_qcnt <= 2'd2; end
        default: r_drop <= 1'b1;
      endcase
    end
  end

  assign score       = r_score;
  assign combo       = r_combo;
  assign mult        = w_mult;
  assign hit         = r_hit;
  assign miss        = r_miss;
  assign evt_valid   = (r_qcnt != 2'd0);
  assign evt_hit     = r_q0;
  assign evt_drop    = r_drop;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_guitar_judge.sv
// Directed bench for guitar_judge: default instance plus a 4-bit-score instance
// for saturation; judgments and queue events are checked by monitor processes.
module tb_guitar_judge;

  typedef struct packed {
    logic        hit;
    logic [31:0] score;
    logic [7:0]  combo;
    logic [2:0]  mult;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0, reset4 = 1'b0;
  logic        strum = 1'b1, strum4 = 1'b0;
  logic [3:0]  buttons = 4'd0, intersections = 4'd0;
  logic        evt_ready = 1'b0;

  logic [31:0] score;
  logic [7:0]  combo, combo4;
  logic [2:0]  mult, mult4;
  logic        hit, miss, evt_valid, evt_hit, evt_drop, dbg;
  logic [3:0]  score4;
  logic        hit4, miss4, evt_valid4, evt_hit4, evt_drop4, dbg4;

  exp_t        exp_q[$];
  exp_t        exp4_q[$];
  logic [0:0]  ev_q[$];
  int          n_vec = 0, n_err = 0;
  bit          use4 = 1'b0;

  always #5 clock = ~clock;

  guitar_judge dut (
    .clock(clock), .reset(reset), .strum(strum), .buttons(buttons),
    .intersections(intersections), .score(score), .combo(combo), .mult(mult),
    .hit(hit), .miss(miss), .evt_valid(evt_valid), .evt_hit(evt_hit),
    .evt_ready(evt_ready), .evt_drop(evt_drop), .o_dbg_state(dbg)
  );

  guitar_judge #(.SCORE_W(4), .HIT_PTS(1), .COMBO_STEP(1)) dut4 (
    .clock(clock), .reset(reset4), .strum(strum4), .buttons(buttons),
    .intersections(intersections), .score(score4), .combo(combo4), .mult(mult4),
    .hit(hit4), .miss(miss4), .evt_valid(evt_valid4), .evt_hit(evt_hit4),
    .evt_ready(evt_ready), .evt_drop(evt_drop4), .o_dbg_state(dbg4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_strum(input logic v);
    if (use4) strum4 = v;
    else      strum  = v;
  endtask

  task automatic strum_raw(input int hi, input int lo);
    set_strum(1'b1);
    repeat (hi) @(negedge clock);
    set_strum(1'b0);
    repeat (lo) @(negedge clock);
  endtask

  task automatic push_exp(input logic h, input int sc, input int co, input int mu, input bit keep);
    exp_t e;
    e.hit = h; e.score = 32'(sc); e.combo = 8'(co); e.mult = 3'(mu);
    if (use4) exp4_q.push_back(e);
    else begin
      exp_q.push_back(e);
      if (keep) ev_q.push_back(h);
    end
  endtask

  task automatic judge(input logic [3:0] b, input logic [3:0] i, input logic h,
                       input int sc, input int co, input int mu, input bit keep);
    push_exp(h, sc, co, mu, keep);
    buttons = b; intersections = i;
    strum_raw(4, 6);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // Judgment monitor for the default instance, including queue pops.
  always begin
    exp_t e;
    @(negedge clock); #1;
    if (hit || miss) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_judge: got hit=%0d miss=%0d expected none", hit, miss);
      end else begin
        e = exp_q.pop_front();
        check("hit", 32'(hit), 32'(e.hit));
        check("miss", 32'(miss), 32'(!e.hit));
        check("score", score, e.score);
        check("combo", 32'(combo), 32'(e.combo));
        check("mult", 32'(mult), 32'(e.mult));
      end
    end
    if (evt_valid && evt_ready) begin
      if (ev_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_event: got evt_hit=%0d expected none", evt_hit);
      end else begin
        check("evt_hit", 32'(evt_hit), 32'(ev_q.pop_front()));
      end
    end
  end

  always begin
    exp_t e;
    @(negedge clock); #1;
    if (hit4 || miss4) begin
      if (exp4_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_judge4: got hit=%0d miss=%0d expected none", hit4, miss4);
      end else begin
        e = exp4_q.pop_front();
        check("hit4", 32'(hit4), 32'(e.hit));
        check("score4", 32'(score4), e.score);
        check("combo4", 32'(combo4), 32'(e.combo));
        check("mult4", 32'(mult4), 32'(e.mult));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with strum held high.
    repeat (3) @(negedge clock);
    #1;
    check("rst_score", score, 0);
    check("rst_combo", 32'(combo), 0);
    check("rst_mult", 32'(mult), 1);
    check("rst_hit", 32'(hit), 0);
    check("rst_miss", 32'(miss), 0);
    check("rst_evt_valid", 32'(evt_valid), 0);
    check("rst_evt_drop", 32'(evt_drop), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    strum = 1'b0;
    repeat (4) @(negedge clock);

    // First hit: pulse three cycles after the rise, one hit queued.
    push_exp(1'b1, 2, 1, 1, 1'b1);
    buttons = 4'b0101; intersections = 4'b0101;
    strum = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("hit_latency", 32'(hit), 1);
    repeat (2) @(negedge clock);
    #1;
    check("q_valid_one", 32'(evt_valid), 1);
    check("q_head_hit", 32'(evt_hit), 1);
    @(negedge clock);
    strum = 1'b0;
    evt_ready = 1'b1;
    repeat (6) @(negedge clock);

    // Hits 2..5 with multiplier step, then misses.
    judge(4'b0101, 4'b0101, 1'b1, 4, 2, 1, 1'b1);
    judge(4'b0101, 4'b0101, 1'b1, 6, 3, 1, 1'b1);
    judge(4'b0101, 4'b0101, 1'b1, 8, 4, 2, 1'b1);
    judge(4'b0101, 4'b0101, 1'b1, 12, 5, 2, 1'b1);
    judge(4'b0011, 4'b0001, 1'b0, 11, 0, 1, 1'b1);
    judge(4'b0011, 4'b0001, 1'b0, 10, 0, 1, 1'b1);

    // Miss with no note at score 0 stays at 0.
    do_reset();
    judge(4'b0000, 4'b0000, 1'b0, 0, 0, 1, 1'b1);
    judge(4'b0110, 4'b0000, 1'b0, 0, 0, 1, 1'b1);

    // Strum inside lockout is discarded; later strum is judged.
    push_exp(1'b1, 2, 1, 1, 1'b1);
    buttons = 4'b0101; intersections = 4'b0101;
    strum_raw(2, 3);
    strum_raw(2, 10);
    judge(4'b0101, 4'b0101, 1'b1, 4, 2, 1, 1'b1);

    // Three judgments with no consumer: third dropped.
    do_reset();
    evt_ready = 1'b0;
    judge(4'b0101, 4'b0101, 1'b1, 2, 1, 1, 1'b1);
    judge(4'b0101, 4'b0101, 1'b1, 4, 2, 1, 1'b1);
    judge(4'b0011, 4'b0001, 1'b0, 3, 0, 1, 1'b0);
    #1;
    check("drop_valid", 32'(evt_valid), 1);
    check("drop_sticky", 32'(evt_drop), 1);
    @(negedge clock);
    evt_ready = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    check("drop_drained", 32'(evt_valid), 0);
    @(negedge clock);

    // Third judgment coincident with a pop: no drop, order hit, miss, hit.
    do_reset();
    evt_ready = 1'b0;
    judge(4'b0101, 4'b0101, 1'b1, 2, 1, 1, 1'b1);
    judge(4'b0011, 4'b0001, 1'b0, 1, 0, 1, 1'b1);
    push_exp(1'b1, 3, 1, 1, 1'b1);
    buttons = 4'b0101; intersections = 4'b0101;
    strum = 1'b1;
    @(negedge clock);
    @(negedge clock);
    evt_ready = 1'b1;
    @(negedge clock);
    evt_ready = 1'b0;
    strum = 1'b0;
    repeat (6) @(negedge clock);
    #1;
    check("coinc_no_drop", 32'(evt_drop), 0);
    check("coinc_valid", 32'(evt_valid), 1);
    @(negedge clock);
    evt_ready = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    check("coinc_drained", 32'(evt_valid), 0);
    @(negedge clock);

    // 4-bit score instance: saturation, then reset during lockout.
    use4 = 1'b1;
    reset4 = 1'b1;
    repeat (4) @(negedge clock);
    judge(4'b0101, 4'b0101, 1'b1, 1, 1, 2, 1'b1);
    judge(4'b0101, 4'b0101, 1'b1, 3, 2, 3, 1'b1);
    judge(4'b0101, 4'b0101, 1'b1, 6, 3, 4, 1'b1);
    judge(4'b0101, 4'b0101, 1'b1, 10, 4, 4, 1'b1);
    judge(4'b0101, 4'b0101, 1'b1, 14, 5, 4, 1'b1);
    judge(4'b0101, 4'b0101, 1'b1, 15, 6, 4, 1'b1);
    push_exp(1'b1, 15, 7, 4, 1'b1);
    strum4 = 1'b1;
    repeat (4) @(negedge clock);
    reset4 = 1'b0;
    strum4 = 1'b0;
    @(negedge clock);
    #1;
    check("lockrst_score", 32'(score4), 0);
    check("lockrst_combo", 32'(combo4), 0);
    check("lockrst_mult", 32'(mult4), 1);
    check("lockrst_hit", 32'(hit4), 0);
    check("lockrst_miss", 32'(miss4), 0);
    check("lockrst_valid", 32'(evt_valid4), 0);
    check("lockrst_drop", 32'(evt_drop4), 0);
    check("lockrst_state", 32'(dbg4), 0);
    @(negedge clock);
    reset4 = 1'b1;
    repeat (6) @(negedge clock);
    #1;

    check("exp_q_left", 32'(exp_q.size()), 0);
    check("exp4_q_left", 32'(exp4_q.size()), 0);
    check("ev_q_left", 32'(ev_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
